// File: rtl/kl8_rx.sv
// Console keyboard receiver: deserialises 8N1 frames from rx and presents each
// character as data plus a keyboard flag, with sticky overrun/framing status.
module kl8_rx #(
  parameter int CLK_HZ    = 25000000,
  parameter int BAUD      = 115200,
  parameter bit MARK_BIT7 = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       kcc,
  output logic [7:0] data,
  output logic       flag,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_TICKS = CLK_HZ / BAUD;
  localparam int HALF      = BIT_TICKS / 2;
  localparam int CW        = $clog2(BIT_TICKS);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT_TICKS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          s1_q, rs_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          flag_q, flag_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          load, ferr_set;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    load     = 1'b0;
    ferr_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rs_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rs_q;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rs_q) begin
            load    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        // Stay here until the line goes idle so a held break cannot start frames.
        cnt_d = '0;
        if (rs_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A load in the same cycle as kcc wins; the old flag then counts as cleared.
    data_d    = load ? {shift_q[7] | MARK_BIT7, shift_q[6:0]} : data_q;
    flag_d    = load ? 1'b1 : (kcc ? 1'b0 : flag_q);
    overrun_d = kcc ? 1'b0 : (overrun_q | (load & flag_q));
    frame_err_d = ferr_set ? 1'b1 : (kcc ? 1'b0 : frame_err_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q        <= 1'b1;
      rs_q        <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      flag_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      s1_q        <= rx;
      rs_q        <= s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      flag_q      <= flag_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data      = data_q;
  assign flag      = flag_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_kl8_rx.sv
// Directed bench for kl8_rx at BIT_TICKS = 16: a scoreboard queue receives each
// byte as it is sent and a monitor pops and compares it when the receiver loads.
module tb_kl8_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       kcc;
  logic [7:0] data, data_m;
  logic       flag, flag_m;
  logic       overrun, overrun_m;
  logic       frame_err, frame_err_m;
  logic       busy, busy_m;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] prev_data;
  logic       prev_flag;

  int  flag_seen;
  bit  busy_ok;

  always #5 clk = ~clk;

  kl8_rx #(.CLK_HZ(16), .BAUD(1), .MARK_BIT7(1'b0)) dut (
    .clk(clk), .reset(reset), .rx(rx), .kcc(kcc),
    .data(data), .flag(flag), .overrun(overrun),
    .frame_err(frame_err), .busy(busy)
  );

  kl8_rx #(.CLK_HZ(16), .BAUD(1), .MARK_BIT7(1'b1)) dut_m (
    .clk(clk), .reset(reset), .rx(rx), .kcc(kcc),
    .data(data_m), .flag(flag_m), .overrun(overrun_m),
    .frame_err(frame_err_m), .busy(busy_m)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-16s observed 0x%0h expected 0x%0h ok", tag, obs, exp);
    end else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: a load shows up as a data change or a rising flag.
  always @(negedge clk) begin
    if (reset === 1'b1 && (data !== prev_data || (flag === 1'b1 && prev_flag !== 1'b1))) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", exp_q.size(), 1);
      end else begin
        check("sb_data", {24'h0, data}, {24'h0, exp_q.pop_front()});
      end
    end
    prev_data = data;
    prev_flag = flag;
  end

  // One 160-cycle frame; kcc_at_load pulses kcc across the stop-sample edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit kcc_at_load);
    logic bitv;
    if (stop) exp_q.push_back(b);
    flag_seen = -1;
    busy_ok   = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 160; c++) begin
      #1;
      if (c < 16)       bitv = 1'b0;
      else if (c < 144) bitv = b[(c - 16) / 16];
      else              bitv = stop;
      rx  = bitv;
      kcc = kcc_at_load && (c == 154);
      @(negedge clk);
      if (c >= 4 && c <= 154 && busy !== 1'b1) busy_ok = 1'b0;
      if (flag_seen < 0 && flag === 1'b1) flag_seen = c;
      @(posedge clk);
    end
    #1;
    kcc = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_kcc;
    @(posedge clk);
    #1 kcc = 1'b1;
    @(posedge clk);
    #1 kcc = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    kcc   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data", {24'h0, data}, 32'h00);
    check("rst_flag", {31'h0, flag}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    idle_cycles(4);

    // Basic frame, load latency and busy coverage
    send_frame(8'h41, 1'b1, 1'b0);
    check("load_latency", {31'h0, (flag_seen >= 154 && flag_seen <= 156)}, 32'h1);
    check("busy_in_frame", {31'h0, busy_ok}, 32'h1);
    check("basic_flag", {31'h0, flag}, 32'h1);
    check("basic_overrun", {31'h0, overrun}, 32'h0);
    check("basic_frame_err", {31'h0, frame_err}, 32'h0);
    check("basic_busy_idle", {31'h0, busy}, 32'h0);
    pulse_kcc();

    // Mark parity on the MARK_BIT7 instance
    send_frame(8'h0D, 1'b1, 1'b0);
    check("mark_data", {24'h0, data_m}, 32'h8D);
    pulse_kcc();

    // Overrun, kcc clear, then kcc coinciding with a load
    send_frame(8'h31, 1'b1, 1'b0);
    send_frame(8'h32, 1'b1, 1'b0);
    check("ovr_data", {24'h0, data}, 32'h32);
    check("ovr_flag", {31'h0, flag}, 32'h1);
    check("ovr_overrun", {31'h0, overrun}, 32'h1);
    pulse_kcc();
    @(negedge clk);
    check("kcc_flag", {31'h0, flag}, 32'h0);
    check("kcc_overrun", {31'h0, overrun}, 32'h0);
    send_frame(8'h34, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b1);
    @(negedge clk);
    check("kccld_flag", {31'h0, flag}, 32'h1);
    check("kccld_overrun", {31'h0, overrun}, 32'h0);
    check("kccld_data", {24'h0, data}, 32'h33);

    // Low stop bit followed by a 40-bit-time break
    send_frame(8'h55, 1'b0, 1'b0);
    rx = 1'b0;
    idle_cycles(640);
    @(negedge clk);
    check("brk_frame_err", {31'h0, frame_err}, 32'h1);
    check("brk_flag", {31'h0, flag}, 32'h1);
    check("brk_data", {24'h0, data}, 32'h33);
    check("brk_busy", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1 rx = 1'b1;
    idle_cycles(6);
    check("brk_end_busy", {31'h0, busy}, 32'h0);
    pulse_kcc();
    @(negedge clk);
    check("kcc_frame_err", {31'h0, frame_err}, 32'h0);
    send_frame(8'h20, 1'b1, 1'b0);
    check("post_brk_data", {24'h0, data}, 32'h20);
    check("post_brk_flag", {31'h0, flag}, 32'h1);

    // False start: 3-cycle glitch
    @(posedge clk);
    #1 rx = 1'b0;
    idle_cycles(3);
    rx = 1'b1;
    idle_cycles(2);
    @(negedge clk);
    check("glitch_busy_hi", {31'h0, busy}, 32'h1);
    idle_cycles(16);
    check("glitch_busy_lo", {31'h0, busy}, 32'h0);
    check("glitch_data", {24'h0, data}, 32'h20);
    check("glitch_flag", {31'h0, flag}, 32'h1);

    // Reset in the middle of the data bits
    @(posedge clk);
    #1 rx = 1'b0;
    idle_cycles(40);
    rx    = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_data", {24'h0, data}, 32'h00);
    check("mid_rst_flag", {31'h0, flag}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_ferr", {31'h0, frame_err}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    idle_cycles(4);
    send_frame(8'hA5, 1'b1, 1'b0);
    check("final_flag", {31'h0, flag}, 32'h1);
    idle_cycles(4);
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/kl8_rx.md
# kl8_rx

Serial keyboard receiver for the PDP-8 console teletype path: deserialises 8N1 frames arriving on the board's RxD pin and presents each character to the CPU's keyboard IOT logic as a data byte plus a keyboard flag. It runs in the divided system clock domain. It is the receive-side counterpart to the transmitter that drives TxD.

## Interface
- CLK_HZ, 25000000, system clock frequency in Hz.
- BAUD, 115200, line rate. BIT_TICKS = CLK_HZ/BAUD (integer truncation, must be ≥ 4). HALF = BIT_TICKS/2.
- MARK_BIT7, 1, when 1, bit 7 of every loaded byte is forced to 1 (ASR-33 mark parity convention).
- clk  in  1  system clock. All logic runs on its rising edge.
- reset  in  1  synchronous, active-low. reset==0 at a rising edge of clk initialises the block.
- rx  in  1  asynchronous serial line, idle high.
- kcc  in  1  one-cycle strobe. Clears flag, overrun and frame_err.
- data  out  8  last correctly framed character.
- flag  out  1  character available.
- overrun  out  1  sticky: a character was loaded while flag was already 1.
- frame_err  out  1  sticky: the stop bit was sampled low.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Input path: 2-flop synchroniser, rx → s1 → rs. Reset loads both flops with 1. All decisions use rs.
- Divider: tick counter cnt, sized ceil(log2(BIT_TICKS)) bits. It is reloaded on every state entry.
- IDLE: cnt = 0. rs==0 → START.
- START: count HALF cycles, then sample rs.
  - rs==1 → false start, return to IDLE. No outputs change.
  - rs==0 → DATA, with bit index = 0.
- DATA: every BIT_TICKS cycles, sample rs into shift register bit[index], LSB first. After index 7 → STOP.
- STOP: after BIT_TICKS cycles, sample rs.
  - rs==1:
    - data ← shift, with bit7 forced to 1 if MARK_BIT7.
    - flag ← 1.
    - overrun ← 1 if flag was already 1 (and kcc is not asserted in the same cycle).
    - Go to IDLE.
  - rs==0:
    - frame_err ← 1.
    - data and flag are unchanged.
    - Go to BREAK.
- BREAK: wait for rs==1, then go to IDLE. Prevents a held-low break from retriggering frames.
- kcc: flag, overrun and frame_err ← 0 on the next edge. The shift/state machine is not affected.
- Simultaneous kcc and load in the same cycle: the load wins for flag (flag = 1) and data. Overrun = 0, because the old flag counts as cleared. A frame_err set in the same cycle as kcc wins (frame_err = 1).
- Overrun policy: new data always overwrites the old data. No buffering beyond one byte.

## Timing
- Reset values: data = 0x00, flag = 0, overrun = 0, frame_err = 0, busy = 0, state = IDLE, cnt = 0.
- Reset mid-frame: the partial frame is discarded and all outputs return to their reset values on that edge.
- Sync latency: an rx edge reaches rs 2 cycles later.
- Sample points:
  - Start bit is sampled HALF cycles after IDLE sees rs==0.
  - Data bit k is sampled HALF + (k+1)·BIT_TICKS cycles after that point.
  - Stop bit is sampled HALF + 9·BIT_TICKS cycles after that point.
- Load latency: flag and data update on the edge that samples the stop bit. Relative to the rx falling edge, this is 3 + HALF + 9·BIT_TICKS cycles (±1), and is fixed for a given build.
- busy rises the cycle after IDLE detects rs==0. busy falls on the edge that returns the state to IDLE.
- Back-to-back frames: a start bit that begins immediately after the stop sample is accepted. There is no idle gap requirement.
- Outputs are registered. There is no combinational path from rx or kcc to any output.

## Test plan
All scenarios use CLK_HZ = 16 and BAUD = 1, so BIT_TICKS = 16 and HALF = 8.
- Basic frame: hold reset = 0 for 2 cycles. Send 0x41 with MARK_BIT7 = 0 → data = 0x41 and flag = 1 at 3 + 8 + 144 cycles (±1) after the start edge. busy is high throughout the frame. overrun = 0, frame_err = 0.
- Mark parity: send 0x0D with MARK_BIT7 = 1 → data = 0x8D.
- Overrun and kcc: send 0x31, then 0x32 with no kcc → data = 0x32, flag = 1, overrun = 1. Pulse kcc → flag = 0 and overrun = 0 next cycle. Assert kcc in the exact cycle of a later load → flag = 1, overrun = 0.
- Framing and break: send 0x55 with a low stop bit, then hold rx low for 40 bit times → frame_err = 1, flag and data unchanged, no spurious frames. rx high then 0x20 → data = 0x20, flag = 1.
- False start: 3-cycle low glitch on rx → state returns to IDLE and no output changes. Reset asserted mid-DATA → all outputs at reset values. A following full frame of 0xA5 is received correctly.
